// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : shared types and constants for the UART receive path
// Rev 1.0
// ============================================================================
package uart_pkg;

  localparam int DEF_CLKS_PER_BIT = 868;
  localparam int DEF_FIFO_DEPTH   = 8;
  localparam int DATA_W           = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo_if.sv
`default_nettype none
// ============================================================================
// uart_rx_fifo_if : serial line input plus the CPU-side read/pop/flag bundle
// Rev 1.0
// ============================================================================
interface uart_rx_fifo_if #(
  parameter int FIFO_DEPTH = uart_pkg::DEF_FIFO_DEPTH
) ();
  import uart_pkg::*;

  logic                        rxd;
  logic                        rx_pop;
  logic                        err_clr;
  logic [DATA_W-1:0]           rx_data;
  logic                        rx_valid;
  logic [$clog2(FIFO_DEPTH):0] rx_level;
  logic                        frame_err;
  logic                        overrun;

  modport master (
    output rxd, rx_pop, err_clr,
    input  rx_data, rx_valid, rx_level, frame_err, overrun
  );

  modport slave (
    input  rxd, rx_pop, err_clr,
    output rx_data, rx_valid, rx_level, frame_err, overrun
  );

endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// sync_fifo : single-clock show-ahead FIFO; head reads 0 while empty
// Rev 1.0
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + 1'b1;
      end
      if (do_pop) begin
        rptr <= rptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign head = empty ? '0 : mem[rptr];

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// uart_rx_fifo : 8N1 oversampling receiver feeding a show-ahead byte FIFO
// Rev 1.0
// ============================================================================
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_rx_fifo_if.slave bus
);
  localparam int              BW       = $clog2(CLKS_PER_BIT);
  localparam int              LW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0]   BIT_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0]   BIT_MID  = BW'(CLKS_PER_BIT / 2 - 1);

  logic              sync1;
  logic              rxs;
  logic              rxs_prev;
  rx_state_t         state;
  logic [BW-1:0]     bcnt;
  logic [2:0]        bidx;
  logic [DATA_W-1:0] shreg;
  logic              frame_err;
  logic              overrun;
  logic              push;
  logic              fifo_full;
  logic              fifo_empty;
  logic [LW-1:0]     level;
  logic [DATA_W-1:0] head;

  // Idle-high reset values keep the edge detector quiet coming out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
    end else begin
      sync1    <= bus.rxd;
      rxs      <= sync1;
      rxs_prev <= rxs;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bcnt      <= '0;
      bidx      <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
    end else begin
      if (bus.err_clr) begin
        frame_err <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (rxs_prev && !rxs) begin
            state <= START;
            bcnt  <= '0;
          end
        end
        START: begin
          if (bcnt == BIT_MID) begin
            bcnt  <= '0;
            bidx  <= '0;
            state <= rxs ? IDLE : DATA;
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
        DATA: begin
          if (bcnt == BIT_LAST) begin
            bcnt  <= '0;
            shreg <= {rxs, shreg[DATA_W-1:1]};
            bidx  <= bidx + 1'b1;
            if (bidx == 3'd7) begin
              state <= STOP;
            end
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
        STOP: begin
          if (bcnt == BIT_LAST) begin
            bcnt <= '0;
            if (rxs) begin
              state <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_HIGH;
            end
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          // A held-low break yields one error; re-arm only once the line idles.
          if (rxs) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign push = (state == STOP) && (bcnt == BIT_LAST) && rxs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else begin
      if (bus.err_clr) begin
        overrun <= 1'b0;
      end
      if (push && fifo_full && !bus.rx_pop) begin
        overrun <= 1'b1;
      end
    end
  end

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (shreg),
    .pop       (bus.rx_pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  assign bus.rx_data   = head;
  assign bus.rx_valid  = !fifo_empty;
  assign bus.rx_level  = level;
  assign bus.frame_err = frame_err;
  assign bus.overrun   = overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// tb_uart_rx_fifo : directed frames with a pop-side scoreboard and flag checks
// Rev 1.0
// ============================================================================
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int CPB   = 16;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  logic [DATA_W-1:0] exp_q [$];

  always #5 clk = ~clk;

  uart_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

  uart_rx_fifo #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    bus.rxd = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      bus.rxd = d[i];
      idle(CPB);
    end
    bus.rxd = stop_bit;
    idle(CPB);
  endtask

  task automatic pop_one();
    bus.rx_pop = 1'b1;
    @(negedge clk);
    bus.rx_pop = 1'b0;
  endtask

  task automatic clr_err();
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
  endtask

  // Scoreboard monitor: every accepted pop must present the oldest expected byte.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && bus.rx_pop) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_byte", 32'(bus.rx_valid), 32'h0);
        end else if (!bus.rx_valid) begin
          total++;
          bad++;
          $display("FAIL sb_missing: got empty want %02h", exp_q[0]);
          void'(exp_q.pop_front());
        end else begin
          check("sb_data", 32'(bus.rx_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst_n       = 1'b0;
    bus.rxd     = 1'b1;
    bus.rx_pop  = 1'b0;
    bus.err_clr = 1'b0;
    idle(3);
    check("rst_valid", 32'(bus.rx_valid), 32'h0);
    check("rst_data",  32'(bus.rx_data),  32'h0);
    check("rst_level", 32'(bus.rx_level), 32'h0);
    check("rst_ferr",  32'(bus.frame_err), 32'h0);
    check("rst_ovr",   32'(bus.overrun),  32'h0);
    rst_n = 1'b1;
    idle(10);

    // Single byte, exact latency from the line edge to rx_valid.
    exp_q.push_back(8'hA5);
    fork
      send_frame(8'hA5, 1'b1);
      begin
        lat = 0;
        while (!bus.rx_valid && lat < 200) begin
          @(negedge clk);
          lat++;
        end
        check("a5_latency", 32'(lat), 32'd155);
        check("a5_data",  32'(bus.rx_data),  32'hA5);
        check("a5_level", 32'(bus.rx_level), 32'h1);
      end
    join
    pop_one();
    check("a5_pop_valid", 32'(bus.rx_valid), 32'h0);
    check("a5_pop_data",  32'(bus.rx_data),  32'h0);
    check("a5_pop_level", 32'(bus.rx_level), 32'h0);

    // Short glitch rejected at the start-bit midpoint.
    bus.rxd = 1'b0;
    idle(4);
    bus.rxd = 1'b1;
    idle(40);
    check("glitch_level", 32'(bus.rx_level), 32'h0);
    check("glitch_ferr",  32'(bus.frame_err), 32'h0);

    // Bad stop bit followed by a long break, then a clean frame.
    send_frame(8'h3C, 1'b0);
    check("ferr_set",   32'(bus.frame_err), 32'h1);
    check("ferr_level", 32'(bus.rx_level),  32'h0);
    idle(20 * CPB);
    check("break_level", 32'(bus.rx_level), 32'h0);
    check("break_valid", 32'(bus.rx_valid), 32'h0);
    bus.rxd = 1'b1;
    idle(CPB);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    check("after_break_level", 32'(bus.rx_level), 32'h1);
    pop_one();
    check("ferr_sticky", 32'(bus.frame_err), 32'h1);
    clr_err();
    check("ferr_clr", 32'(bus.frame_err), 32'h0);

    // Nine back-to-back frames into an eight-entry FIFO.
    for (int v = 0; v < 9; v++) begin
      if (v < 8) exp_q.push_back(8'(v));
      send_frame(8'(v), 1'b1);
    end
    check("ovr_level", 32'(bus.rx_level), 32'h8);
    check("ovr_set",   32'(bus.overrun),  32'h1);
    for (int i = 0; i < 8; i++) pop_one();
    check("ovr_drain_valid", 32'(bus.rx_valid), 32'h0);
    clr_err();
    check("ovr_clr", 32'(bus.overrun), 32'h0);

    // Full FIFO with a pop landing in the push cycle of the ninth byte.
    for (int v = 8'h10; v < 8'h18; v++) begin
      exp_q.push_back(8'(v));
      send_frame(8'(v), 1'b1);
    end
    check("fill_level", 32'(bus.rx_level), 32'h8);
    exp_q.push_back(8'h18);
    fork
      send_frame(8'h18, 1'b1);
      begin
        idle(154);
        pop_one();
      end
    join
    check("pushpop_ovr",   32'(bus.overrun),  32'h0);
    check("pushpop_level", 32'(bus.rx_level), 32'h8);
    for (int i = 0; i < 8; i++) pop_one();
    check("pushpop_drain_valid", 32'(bus.rx_valid), 32'h0);

    // Reset in the middle of a frame flushes the FIFO and abandons the frame.
    send_frame(8'h77, 1'b1);
    check("pre_rst_level", 32'(bus.rx_level), 32'h1);
    fork
      send_frame(8'hFF, 1'b1);
      begin
        idle(CPB + 4 * CPB + CPB / 2);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_valid", 32'(bus.rx_valid), 32'h0);
        check("midrst_data",  32'(bus.rx_data),  32'h0);
        check("midrst_level", 32'(bus.rx_level), 32'h0);
        check("midrst_ferr",  32'(bus.frame_err), 32'h0);
        check("midrst_ovr",   32'(bus.overrun),  32'h0);
        idle(3);
        rst_n = 1'b1;
      end
    join
    idle(CPB);
    check("postrst_level", 32'(bus.rx_level), 32'h0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    check("postrst_one", 32'(bus.rx_level), 32'h1);
    pop_one();
    check("postrst_empty", 32'(bus.rx_valid), 32'h0);

    idle(4);
    check("sb_leftover", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Serial receive front end for the memory-mapped GPIO/UART peripheral. Oversamples the asynchronous UART line, frames 8N1 characters, and buffers them in a small show-ahead FIFO. The GPIO load path reads the head byte, the valid flag and the error flags, and pops one byte per read. It replaces the bare byte/byte-read pair so back-to-back characters are not lost between CPU polls.

## Interface
- CLKS_PER_BIT, default 868: clock cycles per bit (100 MHz / 115200); legal range is 8 or more.
- FIFO_DEPTH, default 8: number of buffered bytes; must be a power of two, 2 or more.
- clk  in  1  single system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rxd  in  1  raw serial line; asynchronous; idle high.
- rx_pop  in  1  one-cycle strobe that removes the head byte.
- err_clr  in  1  one-cycle strobe that clears both sticky error flags.
- rx_data  out  8  head byte of the FIFO; 0 when empty.
- rx_valid  out  1  FIFO is non-empty.
- rx_level  out  $clog2(FIFO_DEPTH)+1  current number of bytes held.
- frame_err  out  1  sticky; a frame arrived with a stop bit of 0.
- overrun  out  1  sticky; a good byte was dropped because the FIFO was full.

## Operation
- rxd passes through a 2-flop synchronizer, reset to 1. All decisions use the synchronized value `rxs`.
- Baud counter `bcnt` counts 0 to CLKS_PER_BIT-1. Bit counter `bidx` counts 0 to 7.
- States and transitions:
  - IDLE: a falling edge on `rxs` (previous 1, current 0) moves to START and sets bcnt to 0.
  - START: when bcnt reaches CLKS_PER_BIT/2-1 (mid-bit), check `rxs`. If `rxs`=1 it was a glitch: return to IDLE, nothing recorded. If `rxs`=0, go to DATA and set bcnt and bidx to 0.
  - DATA: at each bcnt = CLKS_PER_BIT-1, shift `rxs` into the shift register MSB (LSB-first receive) and increment bidx. After bit 7, go to STOP.
  - STOP: at bcnt = CLKS_PER_BIT-1, sample `rxs`.
    - `rxs`=1: push the byte and go to IDLE.
    - `rxs`=0: set frame_err, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rxs`=1, then go to IDLE. A held-low break line therefore produces exactly one frame_err and no phantom bytes.
- FIFO push/pop rules:
  - Push when full and no pop: the byte is dropped, overrun is set, and FIFO contents are unchanged.
  - Push and pop in the same cycle while full: both succeed; level is unchanged and overrun is not set.
  - Pop when empty: ignored.
  - Push and pop in the same cycle while non-full: both succeed; level is unchanged.
- Pointers are $clog2(FIFO_DEPTH) bits wide and wrap naturally.
- Sticky flags: a set event and err_clr in the same cycle leaves the flag set (set wins).

## Timing
- Every output resets to 0, and the state resets to IDLE.
- Reset asserted mid-frame abandons the frame and empties the FIFO. The next clean frame after release is received normally.
- Latency:
  - The synchronizer adds 2 cycles.
  - The push happens in the cycle where bcnt = CLKS_PER_BIT-1 in STOP.
  - rx_valid, rx_data and rx_level update on the next edge.
  - The stop-bit midpoint falls about 9.5 bit times after the line edge.
- rx_pop takes effect at the edge where it is sampled. rx_data shows the next entry (or 0) one cycle later. There is no wait state; rx_pop may be asserted every cycle.
- The receiver re-arms in IDLE immediately after the stop-bit sample. It accepts start bits that follow with zero idle gap.

## Structure
- A shared package `uart_pkg` holds:
  - the receiver state typedef (IDLE, START, DATA, STOP, WAIT_HIGH);
  - the default CLKS_PER_BIT and FIFO_DEPTH constants;
  - the 8-bit data width constant.
- A natural sub-module is `sync_fifo`: parameterized width and depth, show-ahead output, push/pop/full/empty/level. It can be reused later by the TX side.
- The framing FSM, baud counter and synchronizer stay in `uart_rx_fifo`.

## Test plan
All scenarios use CLKS_PER_BIT=16 and FIFO_DEPTH=8.
- Send 0xA5 as 8N1 → rx_valid rises 2+8+144+1 cycles after the rxd falling edge, with rx_data=0xA5 and rx_level=1. Pulse rx_pop → rx_valid=0, rx_data=0, rx_level=0.
- Drive rxd low for 4 cycles, then high → state returns to IDLE, rx_level stays 0, and frame_err stays 0.
- Send 0x3C with stop bit 0, then hold rxd low for 20 bit times → frame_err=1, rx_level=0, and no further events. Release rxd and send 0x5A → 0x5A is received. Pulse err_clr → frame_err=0.
- Send 0x00 to 0x08 back-to-back with no pops → rx_level=8 and overrun=1. Eight pops return 0x00 to 0x07 in order, then rx_valid=0.
- Fill with 0x10 to 0x17, then pulse rx_pop in the exact push cycle of 0x18 → overrun=0, rx_level=8, and popped bytes are 0x11 to 0x18.
- Assert rst_n=0 during bit 4 of 0xFF → all outputs are 0 during reset. After release, send 0x81 → exactly one byte, 0x81.
